// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared fetch types and constants for imem, fetch queue and decode
package fetch_pkg;

    localparam int INS_W = 32;
    localparam int PC_W  = 32;

    localparam logic [PC_W-1:0] PC_STEP = 4;

    typedef struct packed {
        logic [INS_W-1:0] ins;
        logic [PC_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-side push bus and decode-side pop bus of the fetch queue
interface fetch_queue_if #(
    parameter int DEPTH = 8,
    parameter int INS_W = 32,
    parameter int PC_W  = 32
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic             flush;
    logic [1:0]       in_count;
    logic [INS_W-1:0] in_ins0;
    logic [INS_W-1:0] in_ins1;
    logic [PC_W-1:0]  in_pc;
    logic             in_ready;
    logic [1:0]       out_count;
    logic [INS_W-1:0] out_ins0;
    logic [PC_W-1:0]  out_pc0;
    logic [INS_W-1:0] out_ins1;
    logic [PC_W-1:0]  out_pc1;
    logic [1:0]       pop_count;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output flush, in_count, in_ins0, in_ins1, in_pc, pop_count,
        input  in_ready, out_count, out_ins0, out_pc0, out_ins1, out_pc1, occupancy
    );

    modport slave (
        input  flush, in_count, in_ins0, in_ins1, in_pc, pop_count,
        output in_ready, out_count, out_ins0, out_pc0, out_ins1, out_pc1, occupancy
    );

endinterface

// File: rtl/fq_sat_counter.sv
// rtl/fq_sat_counter.sv - 32-bit saturating event counter
module fq_sat_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [31:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 32'd1;
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - dual-entry fetch queue; FETCH_QUEUE_STATS_EN adds stall/empty counters
module fetch_queue #(
    parameter int DEPTH = 8,
    parameter int INS_W = fetch_pkg::INS_W,
    parameter int PC_W  = fetch_pkg::PC_W
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef FETCH_QUEUE_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] empty_cycles,
`endif
    fetch_queue_if.slave fq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INS_W-1:0] ins;
        logic [PC_W-1:0]  pc;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head1;
    logic [PTR_W-1:0] tail1;
    logic [OCC_W-1:0] occ;
    logic             in_ready;
    logic [1:0]       in_n;
    logic [1:0]       push_n;
    logic [1:0]       out_n;
    logic [1:0]       pop_req;
    logic [1:0]       pop_n;

    assign head1 = head + PTR_W'(1);
    assign tail1 = tail + PTR_W'(1);

    // Ready looks only at registered occupancy, so pushes are all-or-nothing.
    assign in_ready = (occ <= OCC_W'(DEPTH - 2));
    assign in_n     = (fq.in_count == 2'd3) ? 2'd2 : fq.in_count;
    assign push_n   = in_ready ? in_n : 2'd0;
    assign out_n    = (occ >= OCC_W'(2)) ? 2'd2 : occ[1:0];
    assign pop_req  = (fq.pop_count == 2'd3) ? 2'd2 : fq.pop_count;
    assign pop_n    = (pop_req < out_n) ? pop_req : out_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (fq.flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            head <= head + PTR_W'(pop_n);
            tail <= tail + PTR_W'(push_n);
            occ  <= occ + OCC_W'(push_n) - OCC_W'(pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && !fq.flush && (push_n != 2'd0)) begin
            mem[tail] <= '{ins: fq.in_ins0, pc: fq.in_pc};
            if (push_n == 2'd2) begin
                mem[tail1] <= '{ins: fq.in_ins1, pc: fq.in_pc + PC_W'(fetch_pkg::PC_STEP)};
            end
        end
    end

    assign fq.in_ready  = in_ready;
    assign fq.out_count = out_n;
    assign fq.occupancy = occ;
    assign fq.out_ins0  = (out_n != 2'd0) ? mem[head].ins  : '0;
    assign fq.out_pc0   = (out_n != 2'd0) ? mem[head].pc   : '0;
    assign fq.out_ins1  = (out_n == 2'd2) ? mem[head1].ins : '0;
    assign fq.out_pc1   = (out_n == 2'd2) ? mem[head1].pc  : '0;

`ifdef FETCH_QUEUE_STATS_EN
    logic stall_inc;
    logic empty_inc;

    assign stall_inc = (fq.in_count != 2'd0) && !in_ready && !fq.flush;
    assign empty_inc = (occ == '0);

    fq_sat_counter u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    fq_sat_counter u_empty_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (empty_inc),
        .count (empty_cycles)
    );
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue, optional FETCH_QUEUE_STATS_EN counters
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 8;

    logic clk;
    logic rst_n;
    int   n_cmp  = 0;
    int   n_fail = 0;

    fetch_entry_t exp_q [$];
    int unsigned  m_stall = 0;
    int unsigned  m_empty = 0;

    fetch_queue_if #(.DEPTH(DEPTH), .INS_W(INS_W), .PC_W(PC_W)) fi ();

`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] empty_cycles;
`endif

    fetch_queue #(.DEPTH(DEPTH), .INS_W(INS_W), .PC_W(PC_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef FETCH_QUEUE_STATS_EN
        .stall_cycles (stall_cycles),
        .empty_cycles (empty_cycles),
`endif
        .fq           (fi.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares the presented head slots against the scoreboard and retires consumed entries.
    initial begin
        int sz;
        int oc;
        int pr;
        int pe;
        logic [31:0] e_ins0, e_pc0, e_ins1, e_pc1;
        forever begin
            @(negedge clk);
            #4;
            sz = exp_q.size();
            oc = (sz >= 2) ? 2 : sz;
            e_ins0 = '0; e_pc0 = '0; e_ins1 = '0; e_pc1 = '0;
            if (oc >= 1) begin e_ins0 = exp_q[0].ins; e_pc0 = exp_q[0].pc; end
            if (oc == 2) begin e_ins1 = exp_q[1].ins; e_pc1 = exp_q[1].pc; end
            chk("occupancy", 32'(fi.occupancy), sz);
            chk("in_ready", 32'(fi.in_ready), 32'(sz <= DEPTH - 2));
            chk("out_count", 32'(fi.out_count), oc);
            chk("out_ins0", fi.out_ins0, e_ins0);
            chk("out_pc0", fi.out_pc0, e_pc0);
            chk("out_ins1", fi.out_ins1, e_ins1);
            chk("out_pc1", fi.out_pc1, e_pc1);
`ifdef FETCH_QUEUE_STATS_EN
            chk("stall_cycles", stall_cycles, m_stall);
            chk("empty_cycles", empty_cycles, m_empty);
            if (rst_n) begin
                if ((fi.in_count != 2'd0) && (sz > DEPTH - 2) && !fi.flush) m_stall++;
                if (sz == 0) m_empty++;
            end
`endif
            if (rst_n && !fi.flush) begin
                pr = (fi.pop_count == 2'd3) ? 2 : int'(fi.pop_count);
                pe = (pr < oc) ? pr : oc;
                repeat (pe) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step(input logic f, input logic [1:0] cnt, input logic [31:0] i0,
                        input logic [31:0] i1, input logic [31:0] pc, input logic [1:0] pop);
        int  n;
        bit  acc;
        @(negedge clk);
        fi.flush     = f;
        fi.in_count  = cnt;
        fi.in_ins0   = i0;
        fi.in_ins1   = i1;
        fi.in_pc     = pc;
        fi.pop_count = pop;
        n   = (cnt == 2'd0) ? 0 : (cnt == 2'd1) ? 1 : 2;
        acc = !f && (n > 0) && (exp_q.size() <= DEPTH - 2);
        @(posedge clk);
        #1;
        if (f) begin
            exp_q.delete();
        end else if (acc) begin
            exp_q.push_back('{ins: i0, pc: pc});
            if (n == 2) exp_q.push_back('{ins: i1, pc: pc + PC_STEP});
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        m_stall = 0;
        m_empty = 0;
        fi.flush = 1'b0; fi.in_count = 2'd0; fi.pop_count = 2'd0;
        fi.in_ins0 = '0; fi.in_ins1 = '0; fi.in_pc = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        fi.flush = 1'b0; fi.in_count = 2'd0; fi.pop_count = 2'd0;
        fi.in_ins0 = '0; fi.in_ins1 = '0; fi.in_pc = '0;
        apply_reset();
        repeat (4) step(0, 0, 0, 0, 0, 0);

        step(0, 2, 32'h1111_1111, 32'h2222_2222, 32'h40, 0);
        step(0, 0, 0, 0, 0, 0);
        for (int k = 1; k < 4; k++)
            step(0, 2, 32'hA000_0000 + k, 32'hB000_0000 + k, 32'h100 + 32'(k) * 8, 0);
        // Full: held push must be dropped while the head stays put.
        repeat (10) step(0, 2, 32'hDEAD_0000, 32'hDEAD_0001, 32'h900, 0);
        step(0, 2, 32'hDEAD_0002, 32'hDEAD_0003, 32'h908, 1);
        step(0, 2, 32'hDEAD_0004, 32'hDEAD_0005, 32'h910, 0);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 2);
        for (int k = 0; k < 6; k++)
            step(0, 2, 32'hC000_0000 + k, 32'hD000_0000 + k, 32'h2000 + 32'(k) * 8, 2);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 0);

        step(0, 2, 32'hE000_0001, 32'hE000_0002, 32'h3000, 0);
        step(0, 2, 32'hE000_0003, 32'hE000_0004, 32'h3008, 0);
        step(0, 1, 32'hE000_0005, 32'hFFFF_FFFF, 32'h3010, 0);
        step(1, 2, 32'hBAD0_0000, 32'hBAD0_0001, 32'h3014, 1);
        step(0, 2, 32'hF000_0001, 32'hF000_0002, 32'h1000, 0);
        step(0, 3, 32'hF000_0003, 32'hF000_0004, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0, 0);

        step(0, 1, 32'h1234_5678, 0, 32'h4000, 0);
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        m_stall = 0;
        m_empty = 0;
        fi.in_count = 2'd0; fi.pop_count = 2'd0;
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 32'h5555_AAAA, 0, 32'h5000, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
